// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache single-word miss requests onto one shared RAM port.
// Dcache wins by default; a saturating starvation counter forces an icache grant.

module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned WORD_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    // icache side
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    // shared RAM port
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   starve_cnt_q;
    logic              ram_err_q;

    logic d_req;
    logic i_force;
    logic i_active;
    logic d_active;
    logic ram_done;

    assign d_req    = dREN | dWEN;
    assign i_force  = iREN && (starve_cnt_q == CntMax);
    // A granted requester that drops its request aborts the access this cycle.
    assign i_active = (state_q == StServeI) && iREN;
    assign d_active = (state_q == StServeD) && d_req;
    assign ram_done = (ramstate == RamAccess);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            ram_err_q    <= 1'b0;
        end else begin
            if (state_q != StIdle && ramstate == RamError) begin
                ram_err_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (d_req && !i_force) begin
                        state_q <= StServeD;
                    end else if (iREN) begin
                        state_q <= StServeI;
                    end
                end
                StServeD: begin
                    if (!d_req) begin
                        state_q <= StIdle;
                    end else if (ram_done) begin
                        state_q <= StIdle;
                        if (!iREN) begin
                            starve_cnt_q <= '0;
                        end else if (starve_cnt_q != CntMax) begin
                            starve_cnt_q <= starve_cnt_q + CntW'(1);
                        end
                    end
                end
                StServeI: begin
                    if (!iREN) begin
                        state_q <= StIdle;
                    end else if (ram_done) begin
                        state_q      <= StIdle;
                        starve_cnt_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            StServeD: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = d_active & dWEN;
                ramREN   = d_active & dREN & ~dWEN;
            end
            StServeI: begin
                ramaddr = iaddr;
                ramREN  = i_active;
            end
            default: ;
        endcase
    end

    assign iwait   = !(i_active && ram_done);
    assign dwait   = !(d_active && ram_done);
    assign iload   = ramload;
    assign dload   = ramload;
    assign ram_err = ram_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a cycle-level grant model.

module tb_mem_arbiter;

    localparam int unsigned LIMIT = 3;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    int total;
    int bad;

    mem_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .WORD_W      (32)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .ram_err (ram_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST     = 1'b0;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
        repeat (2) cyc();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({iwait, dwait, ramREN, ramWEN, ram_err} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 11000", {iwait, dwait, ramREN, ramWEN, ram_err});
        end
        total++;
        if ({ramaddr, ramstore} !== 64'h0) begin
            bad++;
            $display("FAIL reset_bus: got %h want 0", {ramaddr, ramstore});
        end
        total++;
        if (dut.starve_cnt_q !== 2'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d want 0", dut.starve_cnt_q);
        end
    endtask

    task automatic test_single_i();
        int lows;
        lows = 0;
        do_reset();
        iaddr   = 32'h40;
        ramload = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            iREN     = (c <= 3);
            ramstate = (c == 3) ? ACCESS : BUSY;
            #1;
            if (!iwait) lows++;
            if (c >= 1 && c <= 3) begin
                total++;
                if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
                    bad++;
                    $display("FAIL i_grant_bus c%0d: got %h want %h", c,
                             {ramREN, ramWEN, ramaddr}, {2'b10, 32'h40});
                end
            end
            if (c == 3) begin
                total++;
                if ({iwait, iload} !== {1'b0, 32'hDEADBEEF}) begin
                    bad++;
                    $display("FAIL i_complete: got %h want %h", {iwait, iload},
                             {1'b0, 32'hDEADBEEF});
                end
            end
            if (c == 4) begin
                total++;
                if ({ramREN, iwait} !== 2'b01) begin
                    bad++;
                    $display("FAIL i_release: got %b want 01", {ramREN, iwait});
                end
            end
            cyc();
        end
        total++;
        if (lows != 1) begin
            bad++;
            $display("FAIL i_wait_pulse: got %0d want 1", lows);
        end
    endtask

    task automatic test_both_same_cycle();
        do_reset();
        iaddr    = 32'h80;
        daddr    = 32'h200;
        ramload  = 32'h55AA;
        ramstate = ACCESS;
        iREN     = 1'b1;
        dREN     = 1'b1;
        #1;
        total++;
        if ({iwait, dwait, ramREN} !== 3'b110) begin
            bad++;
            $display("FAIL both_idle: got %b want 110", {iwait, dwait, ramREN});
        end
        cyc();
        total++;
        if ({iwait, dwait, ramREN, ramaddr, dload} !== {3'b101, 32'h200, 32'h55AA}) begin
            bad++;
            $display("FAIL both_d_first: got %h want %h", {iwait, dwait, ramREN, ramaddr, dload},
                     {3'b101, 32'h200, 32'h55AA});
        end
        cyc();
        dREN = 1'b0;
        #1;
        total++;
        if ({iwait, dwait, ramREN, dut.starve_cnt_q} !== 5'b110_01) begin
            bad++;
            $display("FAIL both_gap: got %b want 11001", {iwait, dwait, ramREN, dut.starve_cnt_q});
        end
        cyc();
        total++;
        if ({iwait, dwait, ramREN, ramaddr} !== {3'b011, 32'h80}) begin
            bad++;
            $display("FAIL both_i_second: got %h want %h", {iwait, dwait, ramREN, ramaddr},
                     {3'b011, 32'h80});
        end
        cyc();
        iREN = 1'b0;
        #1;
        total++;
        if (dut.starve_cnt_q !== 2'd0) begin
            bad++;
            $display("FAIL both_cnt_clear: got %0d want 0", dut.starve_cnt_q);
        end
    endtask

    task automatic test_starvation();
        string gs;
        int    cnts[$];
        int    want_cnt[4];
        int    got;
        bit    done;
        gs = "";
        want_cnt = '{1, 2, 3, 0};
        do_reset();
        iREN     = 1'b1;
        iaddr    = 32'h44;
        dWEN     = 1'b1;
        daddr    = 32'h300;
        dstore   = 32'h77;
        ramstate = ACCESS;
        for (int c = 0; c < 8; c++) begin
            #1;
            done = 1'b0;
            if (!dwait) begin
                gs = {gs, "D"};
                done = 1'b1;
            end
            if (!iwait) begin
                gs = {gs, "I"};
                done = 1'b1;
            end
            cyc();
            if (done) cnts.push_back(int'(dut.starve_cnt_q));
        end
        iREN = 1'b0;
        dWEN = 1'b0;
        total++;
        if (gs != "DDDI") begin
            bad++;
            $display("FAIL starve_order: got %s want DDDI", gs);
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < cnts.size()) ? cnts[k] : -1;
            total++;
            if (got != want_cnt[k]) begin
                bad++;
                $display("FAIL starve_cnt%0d: got %0d want %0d", k, got, want_cnt[k]);
            end
        end
    endtask

    task automatic test_write();
        do_reset();
        dWEN     = 1'b1;
        dREN     = 1'b1;
        daddr    = 32'h100;
        dstore   = 32'h1234;
        ramstate = BUSY;
        #1;
        total++;
        if ({ramWEN, ramREN, dwait} !== 3'b001) begin
            bad++;
            $display("FAIL wr_idle: got %b want 001", {ramWEN, ramREN, dwait});
        end
        cyc();
        total++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dwait} !== {2'b10, 32'h100, 32'h1234, 1'b1}) begin
            bad++;
            $display("FAIL wr_busy: got %h want %h", {ramWEN, ramREN, ramaddr, ramstore, dwait},
                     {2'b10, 32'h100, 32'h1234, 1'b1});
        end
        cyc();
        ramstate = ACCESS;
        #1;
        total++;
        if ({ramWEN, dwait} !== 2'b10) begin
            bad++;
            $display("FAIL wr_access: got %b want 10", {ramWEN, dwait});
        end
        cyc();
        dWEN     = 1'b0;
        dREN     = 1'b0;
        ramstate = FREE;
    endtask

    task automatic test_abort();
        do_reset();
        iREN     = 1'b1;
        iaddr    = 32'h60;
        dREN     = 1'b1;
        daddr    = 32'h500;
        ramstate = BUSY;
        cyc();
        total++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h500}) begin
            bad++;
            $display("FAIL abort_grant: got %h want %h", {ramREN, ramaddr}, {1'b1, 32'h500});
        end
        cyc();
        dREN     = 1'b0;
        ramstate = ACCESS;
        #1;
        total++;
        if ({ramREN, ramWEN, dwait, iwait} !== 4'b0011) begin
            bad++;
            $display("FAIL abort_drop: got %b want 0011", {ramREN, ramWEN, dwait, iwait});
        end
        cyc();
        total++;
        if ({ramREN, dwait, iwait} !== 3'b011) begin
            bad++;
            $display("FAIL abort_idle: got %b want 011", {ramREN, dwait, iwait});
        end
        cyc();
        total++;
        if ({ramREN, ramaddr, iwait, dut.starve_cnt_q} !== {1'b1, 32'h60, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL abort_i_next: got %h want %h", {ramREN, ramaddr, iwait, dut.starve_cnt_q},
                     {1'b1, 32'h60, 1'b0, 2'd0});
        end
        cyc();
        iREN     = 1'b0;
        ramstate = FREE;
    endtask

    task automatic test_error_reset();
        do_reset();
        iREN     = 1'b1;
        iaddr    = 32'h90;
        ramstate = ERROR;
        cyc();
        total++;
        if ({iwait, ramREN, ram_err} !== 3'b110) begin
            bad++;
            $display("FAIL err_first: got %b want 110", {iwait, ramREN, ram_err});
        end
        cyc();
        ramstate = FREE;
        #1;
        total++;
        if ({iwait, ramREN, ram_err} !== 3'b111) begin
            bad++;
            $display("FAIL err_set: got %b want 111", {iwait, ramREN, ram_err});
        end
        cyc();
        total++;
        if ({iwait, ram_err} !== 2'b11) begin
            bad++;
            $display("FAIL err_sticky: got %b want 11", {iwait, ram_err});
        end
        nRST = 1'b0;
        #1;
        total++;
        if ({iwait, dwait, ramREN, ramWEN, ram_err, ramaddr, ramstore} !== {5'b11000, 64'h0}) begin
            bad++;
            $display("FAIL err_async_rst: got %h want %h",
                     {iwait, dwait, ramREN, ramWEN, ram_err, ramaddr, ramstore}, {5'b11000, 64'h0});
        end
        cyc();
        nRST = 1'b1;
        iREN = 1'b0;
        cyc();
        total++;
        if ({ramREN, ram_err, dut.starve_cnt_q} !== 4'b0000) begin
            bad++;
            $display("FAIL err_after_rst: got %b want 0000", {ramREN, ram_err, dut.starve_cnt_q});
        end
    endtask

    // Model: who holds the port (0 none, 1 icache, 2 dcache), the streak of
    // dcache wins while icache waited, and whether an error was ever seen.
    task automatic test_random();
        int           m_grant;
        int           m_cnt;
        bit           m_err;
        int           r;
        bit           act_i;
        bit           act_d;
        logic [132:0] got;
        logic [132:0] exp;
        logic [31:0]  e_addr;
        logic [31:0]  e_store;
        do_reset();
        m_grant = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                nRST    = 1'b0;
                m_grant = 0;
                m_cnt   = 0;
                m_err   = 1'b0;
            end else begin
                nRST = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) iREN = !iREN;
            if ($urandom_range(0, 3) == 0) dREN = !dREN;
            if ($urandom_range(0, 5) == 0) dWEN = !dWEN;
            iaddr   = $urandom;
            daddr   = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 15);
            ramstate = (r < 7) ? ACCESS : (r < 11) ? BUSY : (r < 15) ? FREE : ERROR;
            #1;
            act_i   = (m_grant == 1) && iREN;
            act_d   = (m_grant == 2) && (dREN || dWEN);
            e_addr  = (m_grant == 2) ? daddr : (m_grant == 1) ? iaddr : 32'h0;
            e_store = (m_grant == 2) ? dstore : 32'h0;
            exp = {!(act_i && ramstate == ACCESS), !(act_d && ramstate == ACCESS),
                   act_i || (act_d && !dWEN), act_d && dWEN, m_err,
                   e_addr, e_store, ramload, ramload};
            got = {iwait, dwait, ramREN, ramWEN, ram_err, ramaddr, ramstore, iload, dload};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rand_out c%0d: got %h want %h", c, got, exp);
            end
            total++;
            if (int'(dut.starve_cnt_q) != m_cnt) begin
                bad++;
                $display("FAIL rand_cnt c%0d: got %0d want %0d", c, dut.starve_cnt_q, m_cnt);
            end
            if (nRST) begin
                if (m_grant != 0 && ramstate == ERROR) m_err = 1'b1;
                if (m_grant == 0) begin
                    if ((dREN || dWEN) && !(iREN && m_cnt == LIMIT)) m_grant = 2;
                    else if (iREN) m_grant = 1;
                end else if (m_grant == 2) begin
                    if (!(dREN || dWEN)) begin
                        m_grant = 0;
                    end else if (ramstate == ACCESS) begin
                        m_cnt   = iREN ? ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1) : 0;
                        m_grant = 0;
                    end
                end else begin
                    if (!iREN) begin
                        m_grant = 0;
                    end else if (ramstate == ACCESS) begin
                        m_cnt   = 0;
                        m_grant = 0;
                    end
                end
            end
            cyc();
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        nRST     = 1'b0;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
        test_reset();
        test_single_i();
        test_both_same_cycle();
        test_starvation();
        test_write();
        test_abort();
        test_error_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
